// File: rtl/play_judge.sv
// -----------------------------------------------------------------------------
// play_judge
//
// This is the gameplay engine for the minesweeper core. It sits on the far
// side of the screen-state handshake. The screen state machine drives
// screen_state_i. This block returns a registered play_end_o verdict, which
// the screen state machine waits on during GAME_PLAY.
//
// State owned here:
//   - 8x8 mine map. It is built during GAME_MAP_GEN with one LFSR-addressed
//     placement per cycle.
//   - Cursor.
//   - Revealed map.
//   - Mine and revealed-cell counters.
//   - Win/lose verdict.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous, active-low reset
//   screen_state_i   current screen state (GAME_* encodings below)
//   up_i/down_i      single-cycle pulses, move cursor y-1 / y+1
//   left_i/right_i   single-cycle pulses, move cursor x-1 / x+1
//   mid_i            single-cycle pulse, reveal the cell under the cursor
//   rd_addr_i        display read address {y[2:0], x[2:0]}
//   rd_cell_o        {mine, revealed, neighbour_count[3:0]}, combinational
//   cursor_o         cursor {y, x}
//   mine_count_o     distinct mines placed, 0..63
//   revealed_count_o safe cells revealed, 0..63
//   play_end_o       [1] victory, [0] fail; registered, never 2'b11
// -----------------------------------------------------------------------------
module play_judge #(
    parameter logic [5:0] LFSR_SEED = 6'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] screen_state_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       mid_i,
    input  logic [5:0] rd_addr_i,
    output logic [5:0] rd_cell_o,
    output logic [5:0] cursor_o,
    output logic [6:0] mine_count_o,
    output logic [6:0] revealed_count_o,
    output logic [1:0] play_end_o
);

    // Screen state encodings shared with the screen state machine.
    localparam logic [2:0] GAME_START   = 3'd0;
    localparam logic [2:0] GAME_MAP_GEN = 3'd1;
    localparam logic [2:0] GAME_PLAY    = 3'd2;
    localparam logic [2:0] GAME_VICTORY = 3'd3;
    localparam logic [2:0] GAME_FAIL    = 3'd4;

    logic [5:0]  lfsr_reg;
    logic [5:0]  lfsr_next;
    logic [63:0] mine_reg;
    logic [63:0] revealed_reg;
    logic [2:0]  cur_x_reg;
    logic [2:0]  cur_y_reg;
    logic [6:0]  mine_count_reg;
    logic [6:0]  revealed_count_reg;
    logic [1:0]  play_end_reg;

    logic [5:0]  cur_addr;
    logic [6:0]  safe_total;

    // Maximal-length 6-bit LFSR. Zero is never reached, so cell 0 is never
    // mined and always works as a safe first reveal.
    assign lfsr_next  = {lfsr_reg[4:0], lfsr_reg[5] ^ lfsr_reg[4]};
    assign cur_addr   = {cur_y_reg, cur_x_reg};
    assign safe_total = 7'd64 - mine_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg           <= LFSR_SEED;
            mine_reg           <= '0;
            revealed_reg       <= '0;
            cur_x_reg          <= '0;
            cur_y_reg          <= '0;
            mine_count_reg     <= '0;
            revealed_count_reg <= '0;
            play_end_reg       <= '0;
        end else begin
            // The LFSR free-runs in every state.
            lfsr_reg <= lfsr_next;

            case (screen_state_i)
                GAME_START: begin
                    mine_reg           <= '0;
                    revealed_reg       <= '0;
                    cur_x_reg          <= '0;
                    cur_y_reg          <= '0;
                    mine_count_reg     <= '0;
                    revealed_count_reg <= '0;
                    play_end_reg       <= '0;
                end

                GAME_MAP_GEN: begin
                    // A duplicate placement is harmless. The counter tracks
                    // only distinct mines.
                    mine_reg[lfsr_reg] <= 1'b1;
                    if (!mine_reg[lfsr_reg]) begin
                        mine_count_reg <= mine_count_reg + 7'd1;
                    end
                end

                GAME_PLAY: begin
                    if (play_end_reg == 2'b00) begin
                        // The reveal uses the cursor as it was before this
                        // cycle's move.
                        if (mid_i && !revealed_reg[cur_addr]) begin
                            revealed_reg[cur_addr] <= 1'b1;
                            if (mine_reg[cur_addr]) begin
                                play_end_reg <= 2'b01;
                            end else begin
                                revealed_count_reg <= revealed_count_reg + 7'd1;
                                if (revealed_count_reg + 7'd1 == safe_total) begin
                                    play_end_reg <= 2'b10;
                                end
                            end
                        end

                        // Only one move per cycle: up > down > left > right.
                        // Moves saturate at the board edges.
                        if (up_i) begin
                            if (cur_y_reg != 3'd0) cur_y_reg <= cur_y_reg - 3'd1;
                        end else if (down_i) begin
                            if (cur_y_reg != 3'd7) cur_y_reg <= cur_y_reg + 3'd1;
                        end else if (left_i) begin
                            if (cur_x_reg != 3'd0) cur_x_reg <= cur_x_reg - 3'd1;
                        end else if (right_i) begin
                            if (cur_x_reg != 3'd7) cur_x_reg <= cur_x_reg + 3'd1;
                        end
                    end
                end

                GAME_VICTORY, GAME_FAIL: begin
                    // Hold the final board for the end screen.
                end

                default: begin
                end
            endcase
        end
    end

    // Neighbour count for the display read port. For each of the 3x3
    // offsets, the coordinate is widened to 4 bits. This way both -1 and 8
    // land with bit 3 set, which marks the neighbour as off-map.
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [8:0] nb_hit;
    logic [3:0] nb_count;

    assign rd_x = rd_addr_i[2:0];
    assign rd_y = rd_addr_i[5:3];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_nb
            localparam int DY = (gi / 3) - 1;
            localparam int DX = (gi % 3) - 1;
            if (gi == 4) begin : g_self
                // The cell's own mine bit does not contribute.
                assign nb_hit[gi] = 1'b0;
            end else begin : g_other
                logic [3:0] ny;
                logic [3:0] nx;
                assign ny = {1'b0, rd_y} + 4'(DY);
                assign nx = {1'b0, rd_x} + 4'(DX);
                assign nb_hit[gi] = ~ny[3] & ~nx[3] & mine_reg[{ny[2:0], nx[2:0]}];
            end
        end
    endgenerate

    always_comb begin
        nb_count = 4'd0;
        for (int i = 0; i < 9; i++) begin
            nb_count = nb_count + {3'b000, nb_hit[i]};
        end
    end

    assign rd_cell_o        = {mine_reg[rd_addr_i], revealed_reg[rd_addr_i], nb_count};
    assign cursor_o         = cur_addr;
    assign mine_count_o     = mine_count_reg;
    assign revealed_count_o = revealed_count_reg;
    assign play_end_o       = play_end_reg;

endmodule

// File: tb/tb_play_judge.sv
// -----------------------------------------------------------------------------
// tb_play_judge
//
// Directed testbench for play_judge. Every expected value below is worked
// out by hand from the map contents and the cursor path. A small cursor
// model (exp_x/exp_y) drives goto().
// -----------------------------------------------------------------------------
module tb_play_judge;

    localparam logic [2:0] GAME_START   = 3'd0;
    localparam logic [2:0] GAME_MAP_GEN = 3'd1;
    localparam logic [2:0] GAME_PLAY    = 3'd2;
    localparam logic [2:0] GAME_VICTORY = 3'd3;
    localparam logic [2:0] GAME_FAIL    = 3'd4;

    logic       clk;
    logic       rst_n;
    logic [2:0] screen_state_i;
    logic       up_i;
    logic       down_i;
    logic       left_i;
    logic       right_i;
    logic       mid_i;
    logic [5:0] rd_addr_i;
    logic [5:0] rd_cell_o;
    logic [5:0] cursor_o;
    logic [6:0] mine_count_o;
    logic [6:0] revealed_count_o;
    logic [1:0] play_end_o;

    int vectors;
    int miscompares;
    int exp_x;
    int exp_y;

    play_judge #(.LFSR_SEED(6'h01)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .screen_state_i   (screen_state_i),
        .up_i             (up_i),
        .down_i           (down_i),
        .left_i           (left_i),
        .right_i          (right_i),
        .mid_i            (mid_i),
        .rd_addr_i        (rd_addr_i),
        .rd_cell_o        (rd_cell_o),
        .cursor_o         (cursor_o),
        .mine_count_o     (mine_count_o),
        .revealed_count_o (revealed_count_o),
        .play_end_o       (play_end_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic m);
        up_i = u; down_i = d; left_i = l; right_i = r; mid_i = m;
        step();
        up_i = 1'b0; down_i = 1'b0; left_i = 1'b0; right_i = 1'b0; mid_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] addr, input logic [5:0] exp);
        rd_addr_i = addr;
        #1;
        chk(tag, 32'(rd_cell_o), 32'(exp));
    endtask

    // Walk the cursor to (tx, ty) with single pulses, tracking the model.
    task automatic goto(input int tx, input int ty);
        while (exp_y > ty) begin pulse(1, 0, 0, 0, 0); exp_y--; end
        while (exp_y < ty) begin pulse(0, 1, 0, 0, 0); exp_y++; end
        while (exp_x > tx) begin pulse(0, 0, 1, 0, 0); exp_x--; end
        while (exp_x < tx) begin pulse(0, 0, 0, 1, 0); exp_x++; end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_x = 0;
        exp_y = 0;
        rst_n = 1'b0;
        screen_state_i = GAME_START;
        up_i = 1'b0; down_i = 1'b0; left_i = 1'b0; right_i = 1'b0; mid_i = 1'b0;
        rd_addr_i = '0;

        // ---- reset held, GAME_START for 10 cycles ----
        repeat (10) step();
        chk("rst_cursor", 32'(cursor_o), 32'h00);
        chk("rst_mines", 32'(mine_count_o), 32'd0);
        chk("rst_revealed", 32'(revealed_count_o), 32'd0);
        chk("rst_play_end", 32'(play_end_o), 32'd0);
        for (int a = 0; a < 64; a++) begin
            rd_chk("rst_rd_cell", 6'(a), 6'h00);
        end
        step();

        // ---- map generation from seed 01: mines at 01,02,04,08 ----
        screen_state_i = GAME_MAP_GEN;
        rst_n = 1'b1;
        repeat (4) step();
        chk("gen_mine_count", 32'(mine_count_o), 32'd4);
        rd_chk("gen_rd_00", 6'h00, 6'h02);   // neighbours 01,08 mined
        rd_chk("gen_rd_09", 6'h09, 6'h03);   // neighbours 01,02,08 mined
        rd_chk("gen_rd_01", 6'h01, 6'h22);   // mine; neighbours 02,08
        rd_chk("gen_rd_04", 6'h04, 6'h20);   // mine; no mined neighbours
        rd_chk("gen_rd_3f", 6'h3F, 6'h00);

        // ---- cursor movement ----
        screen_state_i = GAME_PLAY;
        pulse(0, 0, 1, 0, 0);
        chk("left_sat", 32'(cursor_o), 32'h00);
        repeat (9) pulse(0, 0, 0, 1, 0);
        chk("right_sat", 32'(cursor_o), 32'h07);
        pulse(1, 1, 0, 0, 0);
        chk("up_beats_down", 32'(cursor_o), 32'h07);
        repeat (9) pulse(0, 1, 0, 0, 0);
        chk("down_sat", 32'(cursor_o), 32'h3F);
        pulse(0, 1, 1, 1, 0);                 // down wins, saturated: no left
        chk("down_beats_left", 32'(cursor_o), 32'h3F);
        pulse(0, 0, 1, 1, 0);                 // left wins over right
        chk("left_beats_right", 32'(cursor_o), 32'h3E);
        exp_x = 6; exp_y = 7;
        goto(0, 0);
        chk("back_home", 32'(cursor_o), 32'h00);

        // ---- reveal safe cell 00, then mine 01 ----
        pulse(0, 0, 0, 0, 1);
        chk("reveal_00_count", 32'(revealed_count_o), 32'd1);
        chk("reveal_00_end", 32'(play_end_o), 32'd0);
        rd_chk("reveal_00_rd", 6'h00, 6'h12);
        pulse(0, 0, 0, 1, 0);
        chk("cursor_01", 32'(cursor_o), 32'h01);
        pulse(0, 0, 0, 0, 1);
        chk("mine_fail", 32'(play_end_o), 32'd1);
        chk("mine_count_keep", 32'(revealed_count_o), 32'd1);
        rd_chk("mine_rd_01", 6'h01, 6'h32);
        pulse(0, 0, 0, 1, 1);
        pulse(0, 1, 0, 0, 1);
        chk("frozen_cursor", 32'(cursor_o), 32'h01);
        chk("frozen_end", 32'(play_end_o), 32'd1);
        chk("frozen_count", 32'(revealed_count_o), 32'd1);

        screen_state_i = GAME_FAIL;
        repeat (2) step();
        chk("fail_hold", 32'(play_end_o), 32'd1);
        screen_state_i = GAME_START;
        step();
        chk("start_clear_end", 32'(play_end_o), 32'd0);
        chk("start_clear_mines", 32'(mine_count_o), 32'd0);
        chk("start_clear_cursor", 32'(cursor_o), 32'h00);
        rd_chk("start_clear_rd", 6'h01, 6'h00);

        // ---- single mine at 01, win by revealing all 63 safe cells ----
        rst_n = 1'b0;
        step();
        screen_state_i = GAME_MAP_GEN;
        rst_n = 1'b1;
        step();
        chk("one_mine_count", 32'(mine_count_o), 32'd1);
        screen_state_i = GAME_PLAY;
        exp_x = 0; exp_y = 0;
        pulse(0, 0, 0, 0, 1);
        chk("win_first", 32'(revealed_count_o), 32'd1);
        pulse(0, 0, 0, 0, 1);
        chk("rereveal_00", 32'(revealed_count_o), 32'd1);
        for (int idx = 2; idx < 64; idx++) begin
            goto(idx % 8, idx / 8);
            pulse(0, 0, 0, 0, 1);
            if (idx == 62) begin
                chk("pre_win_count", 32'(revealed_count_o), 32'd62);
                chk("pre_win_end", 32'(play_end_o), 32'd0);
            end
        end
        chk("win_end", 32'(play_end_o), 32'd2);
        chk("win_count", 32'(revealed_count_o), 32'd63);
        pulse(0, 0, 1, 0, 0);
        chk("win_frozen", 32'(cursor_o), 32'h3F);
        screen_state_i = GAME_VICTORY;
        step();
        chk("victory_hold", 32'(play_end_o), 32'd2);

        // ---- asynchronous reset mid-game ----
        rst_n = 1'b0;
        step();
        screen_state_i = GAME_MAP_GEN;
        rst_n = 1'b1;
        repeat (4) step();
        screen_state_i = GAME_PLAY;
        exp_x = 0; exp_y = 0;
        pulse(0, 0, 0, 0, 1);
        goto(2, 5);
        chk("pre_rst_cursor", 32'(cursor_o), 32'h2A);
        chk("pre_rst_count", 32'(revealed_count_o), 32'd1);
        chk("pre_rst_mines", 32'(mine_count_o), 32'd4);
        rd_addr_i = 6'h01;
        #2;
        rst_n = 1'b0;
        #1;                                    // well before the next edge
        chk("async_cursor", 32'(cursor_o), 32'h00);
        chk("async_mines", 32'(mine_count_o), 32'd0);
        chk("async_revealed", 32'(revealed_count_o), 32'd0);
        chk("async_end", 32'(play_end_o), 32'd0);
        chk("async_rd_01", 32'(rd_cell_o), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
